// File: rtl/cnn_pkg.sv
// Shared CNN package: FSM state encodings and the default pixel width.
package cnn_pkg;

  localparam int unsigned DATA_W_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } pool_state_e;

endpackage : cnn_pkg

// File: rtl/max_data.sv
// Combinational unsigned maximum of two words; ties return the shared value.
module max_data #(
  parameter int unsigned W = 16
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  output logic [W-1:0] o_max
);

  assign o_max = (i_a >= i_b) ? i_a : i_b;

endmodule : max_data

// File: rtl/maxpool_ctrl.sv
// 2x2 stride-2 max-pool over a raster-order pixel stream, with a valid/ready
// handshake on both sides. Optional macro MAXPOOL_LAST_EN adds out_last,
// which flags the final pooled pixel of a frame.
module maxpool_ctrl
  import cnn_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned IMG_W  = 24,
  parameter int unsigned IMG_H  = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
`ifdef MAXPOOL_LAST_EN
  output logic              out_last,
`endif
  input  logic              out_ready
);

  localparam int unsigned COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int unsigned ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam int unsigned LB_N  = IMG_W / 2;
  localparam int unsigned LB_IW = (LB_N > 1) ? $clog2(LB_N) : 1;

  pool_state_e       r_state;
  logic [COL_W-1:0]  r_col;
  logic [ROW_W-1:0]  r_row;
  logic [DATA_W-1:0] r_hold;
  logic [DATA_W-1:0] r_linebuf [LB_N];
  logic [DATA_W-1:0] r_out_data;
  logic              r_out_valid;
  logic              r_out_last;

  logic              w_in_ready;
  logic              w_accept;
  logic              w_out_hs;
  logic              w_last_px;
  logic              w_lb_wr;
  logic              w_load;
  logic [LB_IW-1:0]  w_lb_idx;
  logic [DATA_W-1:0] w_hmax;
  logic [DATA_W-1:0] w_vmax;

  // Handshake and window-position decode
  assign w_in_ready = (r_state == ST_RUN) && (!r_out_valid || out_ready);
  assign w_accept   = in_valid && w_in_ready;
  assign w_out_hs   = r_out_valid && out_ready;
  assign w_last_px  = (r_row == ROW_W'(IMG_H - 1)) && (r_col == COL_W'(IMG_W - 1));
  assign w_lb_wr    = w_accept && r_col[0] && !r_row[0];
  assign w_load     = w_accept && r_col[0] && r_row[0];
  assign w_lb_idx   = LB_IW'(r_col >> 1);

  assign in_ready  = w_in_ready;
  assign busy      = (r_state != ST_IDLE);
  assign done      = (r_state == ST_FLUSH) && w_out_hs;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
`ifdef MAXPOOL_LAST_EN
  assign out_last  = r_out_last;
`endif

  // Horizontal max of the held even-column pixel and the current odd-column pixel
  max_data #(.W(DATA_W)) u_hmax (
    .i_a   (r_hold),
    .i_b   (in_data),
    .o_max (w_hmax)
  );

  // Vertical max of the stored upper-row pair and the current lower-row pair
  max_data #(.W(DATA_W)) u_vmax (
    .i_a   (r_linebuf[w_lb_idx]),
    .i_b   (w_hmax),
    .o_max (w_vmax)
  );

  // Frame sequencing FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:  if (start) r_state <= ST_RUN;
        ST_RUN:   if (w_accept && w_last_px) r_state <= ST_FLUSH;
        ST_FLUSH: if (w_out_hs) r_state <= ST_IDLE;
        default:  r_state <= ST_IDLE;
      endcase
    end
  end

  // Raster position counters and horizontal holding register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col  <= '0;
      r_row  <= '0;
      r_hold <= '0;
    end else if (r_state == ST_IDLE && start) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_accept) begin
      if (!r_col[0]) r_hold <= in_data;
      if (r_col == COL_W'(IMG_W - 1)) begin
        r_col <= '0;
        r_row <= (r_row == ROW_W'(IMG_H - 1)) ? '0 : r_row + ROW_W'(1);
      end else begin
        r_col <= r_col + COL_W'(1);
      end
    end
  end

  // Line buffer of upper-row horizontal maxima; always written before read
  always_ff @(posedge clk) begin
    if (w_lb_wr) r_linebuf[w_lb_idx] <= w_hmax;
  end

  // Output register: reloads on a closing pixel, otherwise drains on handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_last  <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_vmax;
      r_out_last  <= w_last_px;
    end else if (w_out_hs) begin
      r_out_valid <= 1'b0;
      r_out_last  <= 1'b0;
    end
  end

`ifndef MAXPOOL_LAST_EN
  logic w_unused_last;
  assign w_unused_last = r_out_last;
`endif

endmodule : maxpool_ctrl

// File: tb/tb_maxpool_ctrl.sv
// Self-checking bench for maxpool_ctrl on a 4x4 frame.
module tb_maxpool_ctrl;

  localparam int unsigned DW   = 16;
  localparam int unsigned W    = 4;
  localparam int unsigned H    = 4;
  localparam int unsigned NPIX = W * H;
  localparam int unsigned NOUT = (W / 2) * (H / 2);

  typedef logic [DW-1:0] frame_t [NPIX];

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          busy;
  logic          done;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_ready;
`ifdef MAXPOOL_LAST_EN
  logic          out_last;
`endif

  int errors = 0;
  int checks = 0;

  maxpool_ctrl #(.DATA_W(DW), .IMG_W(W), .IMG_H(H)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
`ifdef MAXPOOL_LAST_EN
    .out_last  (out_last),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: maximum of the 2x2 window k, windows numbered in raster order
  function automatic logic [DW-1:0] win_max(input frame_t f, input int k);
    int base;
    logic [DW-1:0] m;
    base = (k / int'(W / 2)) * 2 * int'(W) + (k % int'(W / 2)) * 2;
    m = f[base];
    if (f[base + 1] > m)          m = f[base + 1];
    if (f[base + int'(W)] > m)    m = f[base + int'(W)];
    if (f[base + int'(W) + 1] > m) m = f[base + int'(W) + 1];
    return m;
  endfunction

  // mode 0: out_ready=1; mode 1: random out_ready; mode 2: 5-cycle stall at first output
  task automatic run_frame(input frame_t f, input int mode, input bit gaps,
                           input bit mid_start, input string name);
    logic [DW-1:0] exp_q [NOUT];
    int pi, oi, closed, phase, stall, cyc;
    bit seen_ov, exp_ov, exp_ir, acc, hs;
    for (int k = 0; k < int'(NOUT); k++) exp_q[k] = win_max(f, k);
    pi = 0; oi = 0; closed = 0; stall = 0; cyc = 0; seen_ov = 0;
    #1;
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    phase = 1;
    while (phase != 0 && cyc < 400) begin
      cyc++;
      in_valid = (pi < int'(NPIX)) && (!gaps || $urandom_range(0, 3) != 0);
      in_data  = (pi < int'(NPIX)) ? f[pi] : DW'($urandom);
      exp_ov   = (closed - oi) > 0;
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ($urandom_range(0, 2) != 0);
        default: begin
          if (exp_ov) seen_ov = 1'b1;
          out_ready = !(seen_ov && stall < 5);
          if (seen_ov && stall < 5) stall++;
        end
      endcase
      start = mid_start && (pi == 5);
      #1;
      exp_ir = (phase == 1) && (!exp_ov || out_ready);
      chk({name, "_busy"}, 32'(busy), 32'(phase != 0));
      chk({name, "_out_valid"}, 32'(out_valid), 32'(exp_ov));
      chk({name, "_in_ready"}, 32'(in_ready), 32'(exp_ir));
      if (exp_ov) chk({name, "_out_data"}, 32'(out_data), 32'(exp_q[oi]));
      hs = exp_ov && out_ready;
      chk({name, "_done"}, 32'(done), 32'(hs && oi == int'(NOUT) - 1));
`ifdef MAXPOOL_LAST_EN
      chk({name, "_out_last"}, 32'(out_last), 32'(exp_ov && oi == int'(NOUT) - 1));
`endif
      acc = in_valid && exp_ir;
      if (acc) begin
        if (((pi / int'(W)) % 2 == 1) && ((pi % int'(W)) % 2 == 1)) closed++;
        pi++;
        if (pi == int'(NPIX)) phase = 2;
      end
      if (hs) begin
        oi++;
        if (oi == int'(NOUT)) phase = 0;
      end
      @(posedge clk);
      @(negedge clk);
    end
    in_valid = 1'b0;
    start    = 1'b0;
    chk({name, "_timeout"}, 32'(phase), 32'd0);
    chk({name, "_n_out"}, 32'(oi), 32'(NOUT));
    chk({name, "_n_in"}, 32'(pi), 32'(NPIX));
    #1;
    chk({name, "_end_busy"}, 32'(busy), 32'd0);
    chk({name, "_end_valid"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    frame_t f_seq, f_uns, f_three, f_rnd;
    int n, cyc;

    for (int i = 0; i < int'(NPIX); i++) f_seq[i] = DW'(i + 1);
    for (int i = 0; i < int'(NPIX); i++) f_three[i] = DW'(3);
    for (int i = 0; i < int'(NPIX); i++) f_uns[i] = DW'($urandom_range(0, 16'h7FFE));
    f_uns[0] = 16'hFFFF;
    f_uns[1] = 16'h0001;
    f_uns[4] = 16'h8000;
    f_uns[5] = 16'h7FFF;

    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
`ifdef MAXPOOL_LAST_EN
    chk("rst_out_last", 32'(out_last), 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);

    // Directed ramp: expect 6, 8, 14, 16
    chk("ramp_w0", 32'(win_max(f_seq, 0)), 32'd6);
    run_frame(f_seq, 0, 1'b0, 1'b0, "ramp");
    run_frame(f_seq, 2, 1'b0, 1'b0, "stall");
    run_frame(f_uns, 1, 1'b1, 1'b0, "unsigned");

    // Abort a frame after 6 accepted pixels, then a clean all-3 frame
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 50) begin
      cyc++;
      in_valid = 1'b1;
      in_data  = DW'(16'hA000 + n);
      out_ready = 1'b1;
      #1;
      if (in_ready) n++;
      @(posedge clk);
      @(negedge clk);
    end
    chk("abort_fed", 32'(n), 32'd6);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_out_data", 32'(out_data), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(f_three, 0, 1'b1, 1'b0, "threes");

    run_frame(f_seq, 0, 1'b1, 1'b1, "midstart");

    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < int'(NPIX); i++) f_rnd[i] = DW'($urandom);
      run_frame(f_rnd, 1, 1'b1, 1'b0, "random");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_maxpool_ctrl
